vx_mem_channel_router: RTL and testbench

// - Splits the single device memory stream below the L3 into NUM_CHANNELS independent memory channels, interleaved on line address.
// - Returns channel responses on one stream through a round-robin merge.
// - Keeps per-channel read/write/pending/latency perf counters, generalising the single-channel top-level memory counters.
// - Sits between the GPU top-level mem_req/mem_rsp bus and the platform memory controllers.

---
 rtl/vx_mem_channel_router.sv | 230 +++++++++++++++++++++++
 tb/tb_vx_mem_channel_router.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_mem_channel_router.sv
// vx_mem_channel_router
// Splits one line-addressed memory request stream into NUM_CHANNELS channels,
// interleaved on the low line-address bits. Channel responses are merged back
// onto a single registered response slot by a round-robin arbiter. Each channel
// keeps read/write/latency counters and a sticky underflow flag.
module vx_mem_channel_router #(
    parameter int NUM_CHANNELS  = 2,
    parameter int ADDR_WIDTH    = 26,
    parameter int DATA_WIDTH    = 512,
    parameter int TAG_WIDTH     = 8,
    parameter int REQ_DEPTH     = 2,
    parameter int PERF_CTR_BITS = 44,
    localparam int CH_BITS      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 0,
    localparam int CH_ADDR_W    = ADDR_WIDTH - CH_BITS,
    localparam int BE_W         = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  reset,

    input  logic                                  in_req_valid,
    input  logic                                  in_req_rw,
    input  logic [BE_W-1:0]                       in_req_byteen,
    input  logic [ADDR_WIDTH-1:0]                 in_req_addr,
    input  logic [DATA_WIDTH-1:0]                 in_req_data,
    input  logic [TAG_WIDTH-1:0]                  in_req_tag,
    output logic                                  in_req_ready,

    output logic                                  in_rsp_valid,
    output logic [DATA_WIDTH-1:0]                 in_rsp_data,
    output logic [TAG_WIDTH-1:0]                  in_rsp_tag,
    input  logic                                  in_rsp_ready,

    output logic [NUM_CHANNELS-1:0]               ch_req_valid,
    output logic [NUM_CHANNELS-1:0]               ch_req_rw,
    output logic [NUM_CHANNELS*BE_W-1:0]          ch_req_byteen,
    output logic [NUM_CHANNELS*CH_ADDR_W-1:0]     ch_req_addr,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0]    ch_req_data,
    output logic [NUM_CHANNELS*TAG_WIDTH-1:0]     ch_req_tag,
    input  logic [NUM_CHANNELS-1:0]               ch_req_ready,

    input  logic [NUM_CHANNELS-1:0]               ch_rsp_valid,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]    ch_rsp_data,
    input  logic [NUM_CHANNELS*TAG_WIDTH-1:0]     ch_rsp_tag,
    output logic [NUM_CHANNELS-1:0]               ch_rsp_ready,

    output logic [NUM_CHANNELS*PERF_CTR_BITS-1:0] perf_reads,
    output logic [NUM_CHANNELS*PERF_CTR_BITS-1:0] perf_writes,
    output logic [NUM_CHANNELS*PERF_CTR_BITS-1:0] perf_latency,
    output logic [NUM_CHANNELS-1:0]               perf_underflow,
    output logic                                  busy
);

    localparam int SEL_W   = (CH_BITS > 0) ? CH_BITS : 1;
    localparam int PTR_W   = $clog2(REQ_DEPTH);
    localparam int CNT_W   = $clog2(REQ_DEPTH + 1);
    localparam int OFS_DAT = TAG_WIDTH;
    localparam int OFS_ADR = OFS_DAT + DATA_WIDTH;
    localparam int OFS_BE  = OFS_ADR + CH_ADDR_W;
    localparam int ENTRY_W = OFS_BE + BE_W + 1;

    // Circular pointer advance; depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(REQ_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    logic [SEL_W-1:0]        req_sel;
    logic [CH_ADDR_W-1:0]    req_ch_addr;
    logic [ENTRY_W-1:0]      req_entry;
    logic                    req_fire;
    logic [NUM_CHANNELS-1:0] fifo_full;
    logic [NUM_CHANNELS-1:0] pending_nz;

    logic                    rsp_valid_p1;
    logic [DATA_WIDTH-1:0]   rsp_data_p1;
    logic [TAG_WIDTH-1:0]    rsp_tag_p1;
    logic [SEL_W-1:0]        rr_ptr;
    logic [SEL_W-1:0]        grant_idx;
    logic                    grant_any;
    logic                    rsp_take;
    logic                    busy_r;

    generate
        if (CH_BITS > 0) begin : g_split
            assign req_sel     = in_req_addr[CH_BITS-1:0];
            assign req_ch_addr = in_req_addr[ADDR_WIDTH-1:CH_BITS];
        end else begin : g_pass
            assign req_sel     = '0;
            assign req_ch_addr = in_req_addr;
        end
    endgenerate

    assign req_entry    = {in_req_rw, in_req_byteen, req_ch_addr, in_req_data, in_req_tag};
    // Ready looks only at the target FIFO's occupancy, never at valid; a pop in
    // the same cycle does not make room early.
    assign in_req_ready = reset && !fifo_full[req_sel];
    assign req_fire     = in_req_valid && in_req_ready;

    genvar i;
    generate
        for (i = 0; i < NUM_CHANNELS; i++) begin : g_ch
            logic [ENTRY_W-1:0]       mem [REQ_DEPTH];
            logic [PTR_W-1:0]         wr_ptr;
            logic [PTR_W-1:0]         rd_ptr;
            logic [CNT_W-1:0]         cnt;
            logic [ENTRY_W-1:0]       head;
            logic                     push;
            logic                     pop;
            logic                     rd_fire;
            logic                     wr_fire;
            logic                     rsp_fire;
            logic [PERF_CTR_BITS-1:0] pending;
            logic [PERF_CTR_BITS-1:0] reads;
            logic [PERF_CTR_BITS-1:0] writes;
            logic [PERF_CTR_BITS-1:0] latency;
            logic                     underflow;

            assign push     = req_fire && (req_sel == SEL_W'(i));
            assign pop      = ch_req_valid[i] && ch_req_ready[i];
            assign head     = mem[rd_ptr];
            assign rd_fire  = pop && !head[ENTRY_W-1];
            assign wr_fire  = pop && head[ENTRY_W-1];
            assign rsp_fire = ch_rsp_valid[i] && ch_rsp_ready[i];

            assign fifo_full[i]    = (cnt == CNT_W'(REQ_DEPTH));
            assign pending_nz[i]   = (pending != '0);
            assign ch_req_valid[i] = (cnt != '0);
            assign ch_req_rw[i]    = head[ENTRY_W-1];
            assign ch_req_byteen[i*BE_W +: BE_W]           = head[OFS_BE +: BE_W];
            assign ch_req_addr[i*CH_ADDR_W +: CH_ADDR_W]   = head[OFS_ADR +: CH_ADDR_W];
            assign ch_req_data[i*DATA_WIDTH +: DATA_WIDTH] = head[OFS_DAT +: DATA_WIDTH];
            assign ch_req_tag[i*TAG_WIDTH +: TAG_WIDTH]    = head[TAG_WIDTH-1:0];
            assign ch_rsp_ready[i] = rsp_take && (grant_idx == SEL_W'(i));

            assign perf_reads[i*PERF_CTR_BITS +: PERF_CTR_BITS]   = reads;
            assign perf_writes[i*PERF_CTR_BITS +: PERF_CTR_BITS]  = writes;
            assign perf_latency[i*PERF_CTR_BITS +: PERF_CTR_BITS] = latency;
            assign perf_underflow[i] = underflow;

            // FIFO storage write; contents are don't-care while empty.
            always_ff @(posedge clk) begin
                if (push) begin
                    mem[wr_ptr] <= req_entry;
                end
            end

            // FIFO pointers and occupancy.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                    cnt    <= '0;
                end else begin
                    if (push) wr_ptr <= ptr_inc(wr_ptr);
                    if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                    if (push && !pop)      cnt <= cnt + 1'b1;
                    else if (!push && pop) cnt <= cnt - 1'b1;
                end
            end

            // Perf counters; latency accumulates the pending count seen this cycle.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    pending   <= '0;
                    reads     <= '0;
                    writes    <= '0;
                    latency   <= '0;
                    underflow <= 1'b0;
                end else begin
                    reads   <= reads + PERF_CTR_BITS'(rd_fire);
                    writes  <= writes + PERF_CTR_BITS'(wr_fire);
                    latency <= latency + pending;
                    if (rd_fire && !rsp_fire) begin
                        pending <= pending + 1'b1;
                    end else if (!rd_fire && rsp_fire) begin
                        if (pending == '0) underflow <= 1'b1;
                        else               pending   <= pending - 1'b1;
                    end
                end
            end
        end
    endgenerate

    // Round-robin pick: the first valid channel at or after rr_ptr wins.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        for (int k = NUM_CHANNELS - 1; k >= 0; k--) begin
            if (ch_rsp_valid[(int'(rr_ptr) + k) % NUM_CHANNELS]) begin
                grant_any = 1'b1;
                grant_idx = SEL_W'((int'(rr_ptr) + k) % NUM_CHANNELS);
            end
        end
    end

    assign rsp_take = reset && grant_any && (!rsp_valid_p1 || in_rsp_ready);

    // --- response slot stage (p1) ---
    // Slot valid and arbiter pointer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rsp_valid_p1 <= 1'b0;
            rr_ptr       <= '0;
        end else if (rsp_take) begin
            rsp_valid_p1 <= 1'b1;
            rr_ptr       <= SEL_W'((int'(grant_idx) + 1) % NUM_CHANNELS);
        end else if (in_rsp_ready) begin
            rsp_valid_p1 <= 1'b0;
        end
    end

    // Slot payload captured from the granted channel.
    always_ff @(posedge clk) begin
        if (rsp_take) begin
            rsp_data_p1 <= ch_rsp_data[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
            rsp_tag_p1  <= ch_rsp_tag[int'(grant_idx)*TAG_WIDTH +: TAG_WIDTH];
        end
    end

    // Busy reflects last cycle's queued, outstanding or undelivered work.
    always_ff @(posedge clk) begin
        if (!reset) busy_r <= 1'b0;
        else        busy_r <= (|ch_req_valid) || (|pending_nz) || rsp_valid_p1;
    end

    assign in_rsp_valid = rsp_valid_p1;
    assign in_rsp_data  = rsp_data_p1;
    assign in_rsp_tag   = rsp_tag_p1;
    assign busy         = busy_r;

endmodule

// File: tb/tb_vx_mem_channel_router.sv
// Testbench for vx_mem_channel_router (2 channels, default widths).
// Directed scenarios followed by randomized traffic, all checked against a
// queue-based reference model of the router.
module tb_vx_mem_channel_router;

    localparam int NC    = 2;
    localparam int AW    = 26;
    localparam int CAW   = 25;
    localparam int DW    = 512;
    localparam int BW    = 64;
    localparam int TW    = 8;
    localparam int DEPTH = 2;
    localparam int PB    = 44;

    logic               clk = 0;
    logic               reset;
    logic               in_req_valid, in_req_rw;
    logic [BW-1:0]      in_req_byteen;
    logic [AW-1:0]      in_req_addr;
    logic [DW-1:0]      in_req_data;
    logic [TW-1:0]      in_req_tag;
    logic               in_req_ready;
    logic               in_rsp_valid;
    logic [DW-1:0]      in_rsp_data;
    logic [TW-1:0]      in_rsp_tag;
    logic               in_rsp_ready;
    logic [NC-1:0]      ch_req_valid, ch_req_rw, ch_req_ready;
    logic [NC*BW-1:0]   ch_req_byteen;
    logic [NC*CAW-1:0]  ch_req_addr;
    logic [NC*DW-1:0]   ch_req_data;
    logic [NC*TW-1:0]   ch_req_tag;
    logic [NC-1:0]      ch_rsp_valid, ch_rsp_ready;
    logic [NC*DW-1:0]   ch_rsp_data;
    logic [NC*TW-1:0]   ch_rsp_tag;
    logic [NC*PB-1:0]   perf_reads, perf_writes, perf_latency;
    logic [NC-1:0]      perf_underflow;
    logic               busy;

    vx_mem_channel_router dut (
        .clk(clk), .reset(reset),
        .in_req_valid(in_req_valid), .in_req_rw(in_req_rw), .in_req_byteen(in_req_byteen),
        .in_req_addr(in_req_addr), .in_req_data(in_req_data), .in_req_tag(in_req_tag),
        .in_req_ready(in_req_ready),
        .in_rsp_valid(in_rsp_valid), .in_rsp_data(in_rsp_data), .in_rsp_tag(in_rsp_tag),
        .in_rsp_ready(in_rsp_ready),
        .ch_req_valid(ch_req_valid), .ch_req_rw(ch_req_rw), .ch_req_byteen(ch_req_byteen),
        .ch_req_addr(ch_req_addr), .ch_req_data(ch_req_data), .ch_req_tag(ch_req_tag),
        .ch_req_ready(ch_req_ready),
        .ch_rsp_valid(ch_rsp_valid), .ch_rsp_data(ch_rsp_data), .ch_rsp_tag(ch_rsp_tag),
        .ch_rsp_ready(ch_rsp_ready),
        .perf_reads(perf_reads), .perf_writes(perf_writes), .perf_latency(perf_latency),
        .perf_underflow(perf_underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic           rw;
        logic [BW-1:0]  be;
        logic [CAW-1:0] addr;
        logic [DW-1:0]  data;
        logic [TW-1:0]  tag;
    } req_t;

    req_t          mq [NC][$];
    int            m_rr;
    bit            m_sv;
    logic [DW-1:0] m_sd;
    logic [TW-1:0] m_st;
    longint        m_pend [NC];
    longint        m_rd   [NC];
    longint        m_wr   [NC];
    longint        m_lat  [NC];
    bit            m_uf   [NC];
    bit            m_busy;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NC; i++) begin
            mq[i].delete();
            m_pend[i] = 0; m_rd[i] = 0; m_wr[i] = 0; m_lat[i] = 0; m_uf[i] = 0;
        end
        m_rr = 0; m_sv = 0; m_busy = 0;
    endtask

    // Compare all outputs with the model for the current inputs, then advance
    // the model and the DUT by one clock.
    task automatic step();
        bit            m_ready, take, busy_n;
        int            sel, g;
        logic [NC-1:0] exp_rr;
        bit            rdf [NC];
        bit            rsf [NC];
        req_t          e;
        #1;
        sel     = int'(in_req_addr[0]);
        m_ready = reset && (mq[sel].size() < DEPTH);
        take = 0; g = 0;
        if (reset && (!m_sv || in_rsp_ready))
            for (int k = 0; k < NC; k++)
                if (!take && ch_rsp_valid[(m_rr + k) % NC]) begin
                    take = 1; g = (m_rr + k) % NC;
                end
        exp_rr = '0;
        if (take) exp_rr[g] = 1'b1;

        chk("in_req_ready", in_req_ready, m_ready);
        chk("ch_rsp_ready", ch_rsp_ready, exp_rr);
        chk("in_rsp_valid", in_rsp_valid, m_sv);
        if (m_sv) begin
            chk("in_rsp_tag", in_rsp_tag, m_st);
            chk("in_rsp_data", in_rsp_data, m_sd);
        end
        chk("busy", busy, m_busy);
        for (int i = 0; i < NC; i++) begin
            chk($sformatf("ch%0d_req_valid", i), ch_req_valid[i], mq[i].size() > 0);
            if (mq[i].size() > 0) begin
                chk($sformatf("ch%0d_req_rw", i), ch_req_rw[i], mq[i][0].rw);
                chk($sformatf("ch%0d_req_addr", i), ch_req_addr[i*CAW +: CAW], mq[i][0].addr);
                chk($sformatf("ch%0d_req_tag", i), ch_req_tag[i*TW +: TW], mq[i][0].tag);
                chk($sformatf("ch%0d_req_data", i), ch_req_data[i*DW +: DW], mq[i][0].data);
                chk($sformatf("ch%0d_req_byteen", i), ch_req_byteen[i*BW +: BW], mq[i][0].be);
            end
            chk($sformatf("perf_reads%0d", i), perf_reads[i*PB +: PB], PB'(m_rd[i]));
            chk($sformatf("perf_writes%0d", i), perf_writes[i*PB +: PB], PB'(m_wr[i]));
            chk($sformatf("perf_latency%0d", i), perf_latency[i*PB +: PB], PB'(m_lat[i]));
            chk($sformatf("perf_underflow%0d", i), perf_underflow[i], m_uf[i]);
        end

        if (!reset) begin
            model_clear();
        end else begin
            busy_n = m_sv;
            for (int i = 0; i < NC; i++) begin
                if (mq[i].size() > 0 || m_pend[i] != 0) busy_n = 1;
                m_lat[i] += m_pend[i];
                rdf[i] = 0; rsf[i] = 0;
                if (ch_req_ready[i] && mq[i].size() > 0) begin
                    e = mq[i].pop_front();
                    if (e.rw) m_wr[i]++;
                    else begin m_rd[i]++; rdf[i] = 1; end
                end
            end
            if (in_req_valid && m_ready) begin
                e.rw = in_req_rw; e.be = in_req_byteen; e.addr = in_req_addr[AW-1:1];
                e.data = in_req_data; e.tag = in_req_tag;
                mq[sel].push_back(e);
            end
            if (take) begin
                m_sv = 1; m_sd = ch_rsp_data[g*DW +: DW]; m_st = ch_rsp_tag[g*TW +: TW];
                m_rr = (g + 1) % NC; rsf[g] = 1;
            end else if (in_rsp_ready) begin
                m_sv = 0;
            end
            for (int i = 0; i < NC; i++) begin
                if (rdf[i] && !rsf[i]) m_pend[i]++;
                else if (!rdf[i] && rsf[i]) begin
                    if (m_pend[i] == 0) m_uf[i] = 1;
                    else m_pend[i]--;
                end
            end
            m_busy = busy_n;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive_req(input logic rw, input logic [AW-1:0] addr, input logic [TW-1:0] tag);
        in_req_valid  = 1; in_req_rw = rw; in_req_addr = addr; in_req_tag = tag;
        in_req_byteen = {2{$urandom}};
        in_req_data   = {16{$urandom}};
    endtask

    task automatic idle();
        in_req_valid = 0;
        ch_rsp_valid = '0;
    endtask

    task automatic pulse_reset();
        idle();
        reset = 0;
        step();
        reset = 1;
    endtask

    logic [TW-1:0] exp_tags [3];

    initial begin
        reset = 0; in_req_valid = 0; in_req_rw = 0; in_req_byteen = '0; in_req_addr = '0;
        in_req_data = '0; in_req_tag = '0; in_rsp_ready = 1; ch_req_ready = '0;
        ch_rsp_valid = '0; ch_rsp_data = '0; ch_rsp_tag = '0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();                       // reset-state comparison while still in reset
        chk("reset_req_ready", in_req_ready, 1'b0);
        reset = 1;

        // Interleaving: 0x10 -> ch0/0x08, 0x11 -> ch1/0x08
        drive_req(0, 26'h10, 8'd1); step();
        chk("s1_ch_valid", ch_req_valid, 2'b01);
        chk("s1_ch0_addr", ch_req_addr[0 +: CAW], 25'h08);
        chk("s1_ch0_tag", ch_req_tag[0 +: TW], 8'd1);
        drive_req(0, 26'h11, 8'd2); step();
        chk("s1_ch1_addr", ch_req_addr[CAW +: CAW], 25'h08);
        chk("s1_ch1_tag", ch_req_tag[TW +: TW], 8'd2);
        idle(); ch_req_ready = 2'b11; step();
        ch_req_ready = 2'b00;

        // Backpressure on ch0 only
        ch_req_ready = 2'b10;
        drive_req(1, 26'h20, 8'd3); step();
        drive_req(1, 26'h22, 8'd4); step();
        drive_req(1, 26'h24, 8'd5);
        #1 chk("s2_full_ready", in_req_ready, 1'b0);
        step();
        drive_req(1, 26'h25, 8'd6);
        #1 chk("s2_odd_ready", in_req_ready, 1'b1);
        step();
        idle(); ch_req_ready = 2'b11;
        repeat (3) step();

        // Round-robin merge with both channels always valid
        pulse_reset();
        ch_rsp_valid = 2'b11; in_rsp_ready = 1;
        ch_rsp_tag   = {8'hB1, 8'hA0};
        ch_rsp_data  = {32{$urandom}};
        exp_tags[0] = 8'hA0; exp_tags[1] = 8'hB1; exp_tags[2] = 8'hA0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("s3_valid%0d", k), in_rsp_valid, 1'b1);
            chk($sformatf("s3_tag%0d", k), in_rsp_tag, exp_tags[k]);
        end
        idle(); repeat (2) step();

        // Read latency on ch1: response 10 cycles after issue
        pulse_reset();
        ch_req_ready = 2'b11;
        drive_req(0, 26'h3, 8'd7); step();
        idle(); step();
        repeat (9) step();
        ch_rsp_valid = 2'b10; ch_rsp_tag = {8'd7, 8'd0}; step();
        idle(); step();
        chk("s4_reads1", perf_reads[PB +: PB], 44'd1);
        chk("s4_latency1", perf_latency[PB +: PB], 44'd10);
        repeat (2) step();
        chk("s4_busy_low", busy, 1'b0);

        // Unsolicited response, then a one-cycle reset
        ch_rsp_valid = 2'b01; ch_rsp_tag = {8'd0, 8'h55}; step();
        idle(); step();
        chk("s5_underflow0", perf_underflow[0], 1'b1);
        pulse_reset();
        chk("s5_uf_cleared", perf_underflow, 2'b00);
        chk("s5_reads_cleared", perf_reads, '0);

        // Reset with queued requests flushes them
        ch_req_ready = 2'b00;
        drive_req(0, 26'h40, 8'd8); step();
        drive_req(0, 26'h42, 8'd9); step();
        pulse_reset();
        chk("s6_flushed", ch_req_valid, 2'b00);
        ch_req_ready = 2'b11;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("s6_no_req%0d", k), ch_req_valid, 2'b00);
        end

        // Randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset         = ($urandom % 400) != 0;
            in_req_valid  = $urandom_range(0, 1);
            in_req_rw     = $urandom_range(0, 1);
            in_req_addr   = AW'($urandom);
            in_req_tag    = TW'($urandom);
            in_req_byteen = {2{$urandom}};
            in_req_data   = {16{$urandom}};
            ch_req_ready  = NC'($urandom);
            in_rsp_ready  = ($urandom % 4) != 0;
            for (int i = 0; i < NC; i++)
                ch_rsp_valid[i] = (m_pend[i] > 0) ? (($urandom % 3) == 0) : (($urandom % 60) == 0);
            ch_rsp_tag  = {2{TW'($urandom)}};
            ch_rsp_data = {32{$urandom}};
            step();
        end
        reset = 1; idle(); step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
